// File: rtl/led_pattern_decoder_if.sv
// LED bus monitor interface: the observed LED bus plus the decoder's status outputs.
// The bench drives through the master modport; the decoder uses the slave modport.
interface led_pattern_decoder_if #(
    parameter int PW = 16
);
    logic [7:0]    led_in;
    logic [1:0]    mode_out;
    logic          mode_valid;
    logic [PW-1:0] step_period;
    logic          err;
    logic          stall;

    modport master (
        output led_in,
        input  mode_out, mode_valid, step_period, err, stall
    );

    modport slave (
        input  led_in,
        output mode_out, mode_valid, step_period, err, stall
    );
endinterface

// File: rtl/led_pattern_decoder.sv
// Watches an 8-bit LED bus and recovers the animation mode and its step period.
// It flags pattern breaks while locked and flags stalls when the bus stops changing.
module led_pattern_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64,
    parameter int PW         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    led_pattern_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
    typedef enum logic [2:0] {CLS_ROL, CLS_ROR, CLS_ALT, CLS_TOG, CLS_NONE} cls_t;

    localparam logic [PW-1:0] TIMEOUT_M1 = PW'(TIMEOUT - 1);
    localparam logic [3:0]    LOCK_N     = 4'(LOCK_COUNT);

    function automatic cls_t classify(input logic [7:0] prev, input logic [7:0] cur);
        logic one_hot;
        one_hot = (prev != 8'h00) && ((prev & (prev - 8'h01)) == 8'h00);
        if (one_hot && cur == {prev[6:0], prev[7]})                     return CLS_ROL;
        else if (one_hot && cur == {prev[0], prev[7:1]})                return CLS_ROR;
        else if ((prev == 8'h55 && cur == 8'hAA) ||
                 (prev == 8'hAA && cur == 8'h55))                       return CLS_ALT;
        else if ((prev == 8'h00 && cur == 8'hFF) ||
                 (prev == 8'hFF && cur == 8'h00))                       return CLS_TOG;
        else                                                            return CLS_NONE;
    endfunction

    logic [7:0]    s1, s2;
    logic          primed;
    logic [PW-1:0] gap_cnt;
    state_t        state, state_nx;
    logic [1:0]    cand, cand_nx;
    logic [3:0]    match, match_nx;
    logic [1:0]    mode_q, mode_nx;
    logic          valid_q, valid_nx;
    logic [PW-1:0] period_q, period_nx;
    logic          err_q, err_nx;
    logic          stall_q, stall_nx;

    logic          change, gap_sat, timeout, is_cls;
    cls_t          cls;
    logic [1:0]    cls_mode;
    logic [3:0]    match_inc;
    logic [PW-1:0] measured;

    assign change    = primed && (s1 != s2);
    assign cls       = classify(s2, s1);
    assign is_cls    = (cls != CLS_NONE);
    assign cls_mode  = cls[1:0];
    assign match_inc = match + 4'd1;
    assign gap_sat   = (gap_cnt == '1);
    assign measured  = gap_sat ? gap_cnt : gap_cnt + PW'(1);
    // A change on the timeout cycle takes priority, so no stall is declared.
    assign timeout   = !change && (gap_cnt >= TIMEOUT_M1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx  = state;
        cand_nx   = cand;
        match_nx  = match;
        mode_nx   = mode_q;
        valid_nx  = valid_q;
        period_nx = period_q;
        err_nx    = 1'b0;
        stall_nx  = stall_q;
        if (change) begin
            stall_nx = 1'b0;
            case (state)
                IDLE: begin
                    if (is_cls) begin
                        cand_nx  = cls_mode;
                        match_nx = 4'd1;
                        state_nx = TRACK;
                    end
                end
                TRACK: begin
                    if (!is_cls) begin
                        state_nx = IDLE;
                        match_nx = 4'd0;
                    end else if (cls_mode == cand) begin
                        match_nx = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_nx  = LOCKED;
                            mode_nx   = cand;
                            valid_nx  = 1'b1;
                            period_nx = measured;
                        end
                    end else begin
                        cand_nx  = cls_mode;
                        match_nx = 4'd1;
                    end
                end
                LOCKED: begin
                    if (is_cls && cls_mode == cand) begin
                        period_nx = measured;
                    end else begin
                        err_nx   = 1'b1;
                        valid_nx = 1'b0;
                        if (is_cls) begin
                            state_nx = TRACK;
                            cand_nx  = cls_mode;
                            match_nx = 4'd1;
                        end else begin
                            state_nx = IDLE;
                            match_nx = 4'd0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            stall_nx = 1'b1;
            state_nx = IDLE;
            valid_nx = 1'b0;
            match_nx = 4'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 8'h00;
            s2       <= 8'h00;
            primed   <= 1'b0;
            gap_cnt  <= '0;
            state    <= IDLE;
            cand     <= 2'd0;
            match    <= 4'd0;
            mode_q   <= 2'd0;
            valid_q  <= 1'b0;
            period_q <= '0;
            err_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            s1       <= bus.led_in;
            s2       <= s1;
            primed   <= 1'b1;
            gap_cnt  <= change ? '0 : (gap_sat ? gap_cnt : gap_cnt + PW'(1));
            state    <= state_nx;
            cand     <= cand_nx;
            match    <= match_nx;
            mode_q   <= mode_nx;
            valid_q  <= valid_nx;
            period_q <= period_nx;
            err_q    <= err_nx;
            stall_q  <= stall_nx;
        end
    end

    assign bus.mode_out    = mode_q;
    assign bus.mode_valid  = valid_q;
    assign bus.step_period = period_q;
    assign bus.err         = err_q;
    assign bus.stall       = stall_q;
endmodule
